// File: rtl/mult8_seq_ctrl_if.sv
// Request/response and shared-multiplier signals for mult8_seq_ctrl.
//   in_valid/in_ready/in_a/in_b : operand request handshake
//   out_valid/out_ready/out_p   : product response handshake
//   mx/my/mo                    : operands to / product from the shared HALF x HALF multiplier
//   mul_busy                    : shared multiplier is in use
// slave is the sequencer side; master is the requester/consumer/multiplier side.
interface mult8_seq_ctrl_if #(
  parameter int unsigned HALF = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [2*HALF-1:0] in_a;
  logic [2*HALF-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [4*HALF-1:0] out_p;
  logic [HALF-1:0]   mx;
  logic [HALF-1:0]   my;
  logic [2*HALF-1:0] mo;
  logic              mul_busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mo,
    output in_ready, out_valid, out_p, mx, my, mul_busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mo,
    input  in_ready, out_valid, out_p, mx, my, mul_busy
  );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// Sequencer computing a 2*HALF x 2*HALF unsigned product with one shared combinational
// HALF x HALF multiplier, four partial products accumulated over four cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mult8_seq_ctrl_if.slave (request, response and shared-multiplier signals)
module mult8_seq_ctrl #(
  parameter int unsigned HALF = 4
) (
  input logic             clk,
  input logic             rst,
  mult8_seq_ctrl_if.slave bus
);

  localparam int unsigned W  = 2 * HALF;
  localparam int unsigned PW = 4 * HALF;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    ra_q, rb_q;
  logic [1:0]      step_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   pp;
  logic            in_ready_q, out_valid_q, mul_busy_q;
  logic [HALF-1:0] mx_sel, my_sel;

  // Operand selection: step0 lo*lo, step1 lo*hi, step2 hi*lo, step3 hi*hi.
  always_comb begin
    mx_sel = '0;
    my_sel = '0;
    if (state_q == StMul) begin
      unique case (step_q)
        2'd0: begin mx_sel = ra_q[HALF-1:0]; my_sel = rb_q[HALF-1:0]; end
        2'd1: begin mx_sel = ra_q[HALF-1:0]; my_sel = rb_q[W-1:HALF]; end
        2'd2: begin mx_sel = ra_q[W-1:HALF]; my_sel = rb_q[HALF-1:0]; end
        2'd3: begin mx_sel = ra_q[W-1:HALF]; my_sel = rb_q[W-1:HALF]; end
      endcase
    end
  end

  // Partial product aligned to its weight; the four terms never overflow PW bits.
  always_comb begin
    pp = '0;
    unique case (step_q)
      2'd0:       pp = {{W{1'b0}}, bus.mo};
      2'd1, 2'd2: pp = {{HALF{1'b0}}, bus.mo, {HALF{1'b0}}};
      2'd3:       pp = {bus.mo, {W{1'b0}}};
    endcase
    acc_d = acc_q + pp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ra_q        <= '0;
      rb_q        <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mul_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            ra_q       <= bus.in_a;
            rb_q       <= bus.in_b;
            acc_q      <= '0;
            step_q     <= '0;
            state_q    <= StMul;
            in_ready_q <= 1'b0;
            mul_busy_q <= 1'b1;
          end
        end
        StMul: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            state_q     <= StDone;
            mul_busy_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          mul_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mul_busy  = mul_busy_q;
  assign bus.out_p     = acc_q;
  assign bus.mx        = mx_sel;
  assign bus.my        = my_sel;

endmodule
